tlul_periph_reg_bridge: RTL and testbench



---
 rtl/tlul_pkg.sv | 36 +++
 rtl/tlul_periph_reg_bridge_req_check.sv | 46 ++++
 rtl/tlul_periph_reg_bridge.sv | 139 +++++++++++++
 tb/tb_tlul_periph_reg_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL bus types, opcodes and error data shared by the peripheral bridge.
package tlul_pkg;

    localparam logic [2:0] Get           = 3'd4;
    localparam logic [2:0] PutFull       = 3'd0;
    localparam logic [2:0] PutPartial    = 3'd1;
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;

    localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_periph_reg_bridge_req_check.sv
// rtl/tlul_periph_reg_bridge_req_check.sv - combinational TL-UL request legality check.
module tlul_req_check
    import tlul_pkg::*;
#(
    parameter int RegAw        = 8,
    parameter bit AllowPartial = 1'b0
) (
    input  logic [2:0]  opcode,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [3:0]  mask,
    output logic        err
);

    logic op_ok;
    logic size_ok;
    logic align_ok;
    logic range_ok;
    logic mask_ok;

    always_comb begin
        op_ok = (opcode == Get) || (opcode == PutFull) || (opcode == PutPartial);

        // Sub-word accesses may only enable lanes inside the addressed size.
        case (size)
            2'd0:    size_ok = (mask[3:1] == 3'b000);
            2'd1:    size_ok = (mask[3:2] == 2'b00);
            2'd2:    size_ok = 1'b1;
            default: size_ok = 1'b0;
        endcase

        align_ok = (address[1:0] == 2'b00);
        range_ok = ((address >> RegAw) == 32'd0);

        if (opcode == PutFull) begin
            mask_ok = (mask == 4'hF);
        end else if (opcode == PutPartial) begin
            mask_ok = AllowPartial || (mask == 4'hF);
        end else begin
            mask_ok = 1'b1;
        end

        err = !(op_ok && size_ok && align_ok && range_ok && mask_ok);
    end

endmodule

// File: rtl/tlul_periph_reg_bridge.sv
// rtl/tlul_periph_reg_bridge.sv - TL-UL device endpoint driving a single-outstanding req/ack register bus.
module tlul_periph_reg_bridge
    import tlul_pkg::*;
#(
    parameter int RegAw         = 8,
    parameter int TimeoutCycles = 64,
    parameter bit AllowPartial  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  tl_h2d_t          tl_i,
    output tl_d2h_t          tl_o,
    output logic             reg_req_o,
    output logic             reg_we_o,
    output logic [RegAw-1:0] reg_addr_o,
    output logic [31:0]      reg_wdata_o,
    output logic [3:0]       reg_be_o,
    input  logic [31:0]      reg_rdata_i,
    input  logic             reg_ack_i,
    input  logic             reg_err_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e state_q, state_d;

    logic             req_err;
    logic             accept;
    logic             timeout_hit;
    logic [2:0]       op_q;
    logic [1:0]       size_q;
    logic [7:0]       source_q;
    logic             we_q;
    logic [RegAw-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [7:0]       cnt_q;
    logic             err_q;
    logic [31:0]      data_q;

    tlul_req_check #(
        .RegAw        (RegAw),
        .AllowPartial (AllowPartial)
    ) u_req_check (
        .opcode  (tl_i.a_opcode),
        .size    (tl_i.a_size),
        .address (tl_i.a_address),
        .mask    (tl_i.a_mask),
        .err     (req_err)
    );

    assign accept      = tl_i.a_valid && (state_q == IDLE);
    assign timeout_hit = (cnt_q == 8'(TimeoutCycles - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tl_i.a_valid) begin
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (reg_ack_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tl_i.d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q     <= '0;
            size_q   <= '0;
            source_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else if (accept) begin
            op_q     <= tl_i.a_opcode;
            size_q   <= tl_i.a_size;
            source_q <= tl_i.a_source;
            we_q     <= (tl_i.a_opcode != Get);
            addr_q   <= tl_i.a_address[RegAw-1:0];
            wdata_q  <= tl_i.a_data;
            be_q     <= tl_i.a_mask;
            cnt_q    <= '0;
            err_q    <= req_err;
            data_q   <= (req_err && tl_i.a_opcode == Get) ? ErrData : 32'd0;
        end else if (state_q == ACCESS) begin
            // A late ack on the final cycle still completes the access normally.
            if (reg_ack_i) begin
                err_q  <= reg_err_i;
                data_q <= (op_q != Get) ? 32'd0 : (reg_err_i ? ErrData : reg_rdata_i);
            end else if (timeout_hit) begin
                err_q  <= 1'b1;
                data_q <= ErrData;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign reg_req_o   = (state_q == ACCESS);
    assign reg_we_o    = we_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_be_o    = be_q;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (state_q == IDLE);
        tl_o.d_valid  = (state_q == RESP);
        tl_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_data   = data_q;
        tl_o.d_error  = err_q;
    end

endmodule

// File: tb/tb_tlul_periph_reg_bridge.sv
// tb/tb_tlul_periph_reg_bridge.sv - self-checking bench for tlul_periph_reg_bridge.
module tb_tlul_periph_reg_bridge;
    import tlul_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_ni;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        reg_req_o, reg_we_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_rdata_i;
    logic        reg_ack_i, reg_err_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Peripheral behaviour: ack during the cfg_ack_at-th cycle of reg_req (0 = never).
    int          cfg_ack_at = 0;
    logic [31:0] cfg_rdata  = '0;
    logic        cfg_err    = 1'b0;
    logic        late_ack   = 1'b0;
    int          req_run    = 0;

    // Model state
    bit          busy = 0;
    bit          m_legal_q;
    int          acc, m_len, resp_start;
    logic [2:0]  m_op;
    logic [1:0]  m_size;
    logic [7:0]  m_src;
    logic [31:0] m_addr, m_data, m_exp_data;
    logic [3:0]  m_mask;
    logic        m_exp_err;
    int          req_seen = 0;

    tlul_periph_reg_bridge #(.RegAw(8), .TimeoutCycles(TO), .AllowPartial(1'b0)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .reg_req_o   (reg_req_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ack_i   (reg_ack_i),
        .reg_err_i   (reg_err_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_legal(input logic [2:0] op, input logic [1:0] sz,
                                   input logic [31:0] ad, input logic [3:0] mk);
        bit known = (op == 3'd4) || (op == 3'd0) || (op == 3'd1);
        int lanes = 1 << sz;
        bit fits  = (sz == 2'd2) || (sz < 2'd2 && (32'(mk) >> lanes) == 0);
        return known && fits && (ad % 4 == 0) && (ad < 256) && (op == 3'd4 || mk == 4'hF);
    endfunction

    always @(posedge clk) begin
        #2;
        if (reg_req_o) begin
            req_run++;
            reg_ack_i = (req_run == cfg_ack_at);
        end else begin
            req_run   = 0;
            reg_ack_i = late_ack;
        end
        reg_rdata_i = late_ack ? 32'h5A5A_0F0F : cfg_rdata;
        reg_err_i   = cfg_err;
    end

    // Model + per-cycle compare, evaluated mid-cycle on settled inputs.
    always @(negedge clk) begin
        if (!rst_ni) begin
            busy = 0;
        end else begin
            bit exp_req, exp_dv;
            exp_req = busy && m_legal_q && (cyc > acc) && (cyc <= acc + m_len);
            exp_dv  = busy && (cyc >= resp_start);
            chk("a_ready", tl_o.a_ready, !busy);
            chk("reg_req", reg_req_o, exp_req);
            chk("d_valid", tl_o.d_valid, exp_dv);
            if (exp_req) begin
                chk("reg_we", reg_we_o, m_op != 3'd4);
                chk("reg_addr", reg_addr_o, m_addr[7:0]);
                chk("reg_be", reg_be_o, m_mask);
                chk("reg_wdata", reg_wdata_o, m_data);
            end
            if (exp_dv) begin
                chk("d_opcode", tl_o.d_opcode, (m_op == 3'd4) ? 3'd1 : 3'd0);
                chk("d_error", tl_o.d_error, m_exp_err);
                chk("d_data", tl_o.d_data, m_exp_data);
                chk("d_size", tl_o.d_size, m_size);
                chk("d_source", tl_o.d_source, m_src);
                chk("d_zero", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
            end
            if (reg_req_o) req_seen++;
            if (exp_dv && tl_i.d_ready) begin
                busy = 0;
            end else if (!busy && tl_i.a_valid) begin
                bit acked;
                busy       = 1;
                acc        = cyc;
                req_seen   = 0;
                m_op       = tl_i.a_opcode;
                m_size     = tl_i.a_size;
                m_src      = tl_i.a_source;
                m_addr     = tl_i.a_address;
                m_mask     = tl_i.a_mask;
                m_data     = tl_i.a_data;
                m_legal_q  = m_legal(m_op, m_size, m_addr, m_mask);
                acked      = (cfg_ack_at >= 1) && (cfg_ack_at <= TO);
                m_len      = acked ? cfg_ack_at : TO;
                resp_start = m_legal_q ? acc + m_len + 1 : acc + 1;
                if (!m_legal_q) begin
                    m_exp_err  = 1'b1;
                    m_exp_data = (m_op == 3'd4) ? 32'hFFFF_FFFF : 32'd0;
                end else if (!acked) begin
                    m_exp_err  = 1'b1;
                    m_exp_data = 32'hFFFF_FFFF;
                end else begin
                    m_exp_err  = cfg_err;
                    m_exp_data = (m_op != 3'd4) ? 32'd0 : (cfg_err ? 32'hFFFF_FFFF : cfg_rdata);
                end
            end
        end
    end

    task automatic do_txn(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [3:0] mk, input logic [31:0] wd, input logic [7:0] src,
                          input int ack_at, input logic [31:0] rd, input logic er, input int hold,
                          input logic lit_err, input logic [31:0] lit_data, input int lit_req);
        int k;
        @(posedge clk); #1;
        cfg_ack_at       = ack_at;
        cfg_rdata        = rd;
        cfg_err          = er;
        tl_i.a_opcode    = op;
        tl_i.a_size      = sz;
        tl_i.a_address   = ad;
        tl_i.a_mask      = mk;
        tl_i.a_data      = wd;
        tl_i.a_source    = src;
        tl_i.a_valid     = 1'b1;
        @(posedge clk); #1;
        tl_i.a_valid     = 1'b0;
        for (k = 0; k < 200 && !tl_o.d_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("resp_within_bound", k < 200, 1'b1);
        chk("lit_d_error", tl_o.d_error, lit_err);
        chk("lit_d_data", tl_o.d_data, lit_data);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
        chk("lit_a_ready_after_resp", tl_o.a_ready, 1'b1);
        chk("lit_req_cycles", req_seen, lit_req);
        cfg_ack_at = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        tl_i        = '0;
        reg_ack_i   = 1'b0;
        reg_err_i   = 1'b0;
        reg_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("rst_a_ready", tl_o.a_ready, 1'b1);
        chk("rst_reg_req", reg_req_o, 1'b0);
        chk("rst_reg_bus", {reg_we_o, reg_addr_o, reg_be_o}, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_d_valid", tl_o.d_valid, 1'b0);
        chk("rst_d_fields", {tl_o.d_error, tl_o.d_data}, 0);

        // op, size, addr, mask, wdata, src, ack_at, rdata, err, hold, exp_err, exp_data, req cycles
        do_txn(3'd4, 2'd2, 32'h04,  4'hF, 32'h0,         8'h11, 1,  32'hA5A5_1234, 1'b0, 0, 1'b0, 32'hA5A5_1234, 1);
        do_txn(3'd0, 2'd2, 32'h10,  4'hF, 32'hDEAD_BEEF, 8'h22, 2,  32'h0,         1'b0, 3, 1'b0, 32'h0,         2);
        do_txn(3'd1, 2'd2, 32'h20,  4'h3, 32'h1111_2222, 8'h33, 1,  32'h0,         1'b0, 0, 1'b1, 32'h0,         0);
        do_txn(3'd4, 2'd2, 32'h102, 4'hF, 32'h0,         8'h44, 1,  32'h0,         1'b0, 1, 1'b1, 32'hFFFF_FFFF, 0);
        do_txn(3'd4, 2'd2, 32'h08,  4'hF, 32'h0,         8'h55, 0,  32'h0,         1'b0, 0, 1'b1, 32'hFFFF_FFFF, 64);
        late_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 late_ack = 1'b0;
        repeat (2) @(posedge clk);
        do_txn(3'd4, 2'd2, 32'h0C,  4'hF, 32'h0,         8'h66, 64, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h1234_5678, 64);
        do_txn(3'd4, 2'd0, 32'h30,  4'h1, 32'h0,         8'h77, 3,  32'hCAFE_0000, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 3);
        do_txn(3'd3, 2'd2, 32'h40,  4'hF, 32'h0,         8'h88, 1,  32'h0,         1'b0, 2, 1'b1, 32'h0,         0);

        // Reset pulse while the access is outstanding.
        @(posedge clk); #1;
        cfg_ack_at     = 0;
        tl_i.a_opcode  = 3'd4;
        tl_i.a_size    = 2'd2;
        tl_i.a_address = 32'h48;
        tl_i.a_mask    = 4'hF;
        tl_i.a_source  = 8'h99;
        tl_i.a_valid   = 1'b1;
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("lit_req_before_reset", req_seen, 5);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        chk("lit_mid_rst_req", reg_req_o, 1'b0);
        chk("lit_mid_rst_dvalid", tl_o.d_valid, 1'b0);
        chk("lit_mid_rst_aready", tl_o.a_ready, 1'b1);
        repeat (4) @(posedge clk);
        do_txn(3'd4, 2'd2, 32'h44, 4'hF, 32'h0, 8'hAA, 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 32'h0BAD_F00D, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
